// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue. Exposes every slot plus a per-slot valid so the
// parent can search pending writes; slot order by age starts at o_rd_ptr.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    output logic [PTR_W:0]   o_count,
    output logic             o_full,
    output wb_entry_t        o_head,
    output logic [PTR_W-1:0] o_rd_ptr,
    output wb_entry_t        o_entries [DEPTH],
    output logic [DEPTH-1:0] o_valid
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_off;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot storage; contents of invalid slots are never observed.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        w_off   = '0;
        o_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PTR_W'(i) - r_rd_ptr;
            o_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    assign o_count   = r_count;
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign o_rd_ptr  = r_rd_ptr;
    assign o_entries = r_mem;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back initiator for the MIPS register file: arbitrates ALU/load results
// into wb_fifo, drains one write per cycle, and answers two pending-write lookups.
// Build option: define WB_BYPASS_EN to enable lookup data forwarding; without it
// o_lk_data* are tied to 0 and only the hit flags are produced.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_addr,
    input  logic [REG_DATA_W-1:0] i_alu_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_addr,
    input  logic [REG_DATA_W-1:0] i_ld_data,
    input  logic                  i_hold,
    output logic                  o_wr_en,
    output logic [REG_ADDR_W-1:0] o_wr_addr,
    output logic [REG_DATA_W-1:0] o_wr_data,
    input  logic [REG_ADDR_W-1:0] i_lk_addr1,
    input  logic [REG_ADDR_W-1:0] i_lk_addr2,
    output logic                  o_lk_hit1,
    output logic                  o_lk_hit2,
    output logic [REG_DATA_W-1:0] o_lk_data1,
    output logic [REG_DATA_W-1:0] o_lk_data2,
    output logic                  o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic                  w_push;
    wb_entry_t             w_push_entry;
    logic                  w_pop;
    logic [PTR_W:0]        w_count;
    logic                  w_full;
    wb_entry_t             w_head;
    logic [PTR_W-1:0]      w_rd_ptr;
    wb_entry_t             w_entries [DEPTH];
    logic [DEPTH-1:0]      w_valid;

    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [REG_DATA_W-1:0] r_wr_data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_head       (w_head),
        .o_rd_ptr     (w_rd_ptr),
        .o_entries    (w_entries),
        .o_valid      (w_valid)
    );

    // Load wins; readies ignore a same-cycle pop so push-into-full never happens.
    assign o_ld_ready  = !w_full;
    assign o_alu_ready = !w_full && !i_ld_valid;

    // Select the accepted source; r0 handshakes complete but enqueue nothing.
    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '{addr: i_alu_addr, data: i_alu_data};
        if (i_ld_valid) begin
            w_push       = o_ld_ready && (i_ld_addr != REG_ZERO);
            w_push_entry = '{addr: i_ld_addr, data: i_ld_data};
        end else begin
            w_push = i_alu_valid && o_alu_ready && (i_alu_addr != REG_ZERO);
        end
    end

    assign w_pop = (w_count != '0) && !i_hold;

    // Drain stage: registered register-file write port; address/data hold when idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= w_head.addr;
                r_wr_data <= w_head.data;
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_empty   = (w_count == '0) && !r_wr_en;

    // Hit search over in-flight write and all live slots; r0 never hits.
    always_comb begin
        o_lk_hit1 = r_wr_en && (r_wr_addr == i_lk_addr1);
        o_lk_hit2 = r_wr_en && (r_wr_addr == i_lk_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_entries[i].addr == i_lk_addr1)) o_lk_hit1 = 1'b1;
            if (w_valid[i] && (w_entries[i].addr == i_lk_addr2)) o_lk_hit2 = 1'b1;
        end
        if (i_lk_addr1 == REG_ZERO) o_lk_hit1 = 1'b0;
        if (i_lk_addr2 == REG_ZERO) o_lk_hit2 = 1'b0;
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] w_idx;

    // Youngest-match data: start at in-flight, then walk slots oldest to youngest.
    always_comb begin
        w_idx      = '0;
        o_lk_data1 = '0;
        o_lk_data2 = '0;
        if (r_wr_en && (r_wr_addr == i_lk_addr1)) o_lk_data1 = r_wr_data;
        if (r_wr_en && (r_wr_addr == i_lk_addr2)) o_lk_data2 = r_wr_data;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_rd_ptr + PTR_W'(k);
            if (w_valid[w_idx] && (w_entries[w_idx].addr == i_lk_addr1))
                o_lk_data1 = w_entries[w_idx].data;
            if (w_valid[w_idx] && (w_entries[w_idx].addr == i_lk_addr2))
                o_lk_data2 = w_entries[w_idx].data;
        end
        if (i_lk_addr1 == REG_ZERO) o_lk_data1 = '0;
        if (i_lk_addr2 == REG_ZERO) o_lk_data2 = '0;
    end
`else
    logic w_unused;

    assign o_lk_data1 = '0;
    assign o_lk_data2 = '0;

    // Slot data and head pointer only feed forwarding; fold them into a sink.
    always_comb begin
        w_unused = ^w_rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            w_unused = w_unused ^ (^w_entries[i].data);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever wr_en is presented.
// Honours WB_BYPASS_EN for the expected lookup data.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        hold;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  lk_addr1, lk_addr2;
    logic        lk_hit1, lk_hit2;
    logic [31:0] lk_data1, lk_data2;
    logic        empty;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_addr  (alu_addr),
        .i_alu_data  (alu_data),
        .i_ld_valid  (ld_valid),
        .o_ld_ready  (ld_ready),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_hold      (hold),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .i_lk_addr1  (lk_addr1),
        .i_lk_addr2  (lk_addr2),
        .o_lk_hit1   (lk_hit1),
        .o_lk_hit2   (lk_hit2),
        .o_lk_data1  (lk_data1),
        .o_lk_data2  (lk_data2),
        .o_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    function automatic logic [31:0] byp(input logic [31:0] d);
`ifdef WB_BYPASS_EN
        return d;
`else
        return 32'h0;
`endif
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write at %0t",
                             wr_addr, wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", wr_data, e.d);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_valid = 0;  ld_addr = 0;  ld_data = 0;
        hold = 0; lk_addr1 = 0; lk_addr2 = 0;

        #2;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_hit1", 32'(lk_hit1), 0);
        nxt(); nxt();
        rst = 1'b0;
        nxt();
        chk("rst_alu_ready", 32'(alu_ready), 1);
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);

        // single ALU write, two-edge latency
        alu_valid = 1; alu_addr = 5; alu_data = 32'h1234_5678; lk_addr1 = 5;
        chk("t1_alu_ready", 32'(alu_ready), 1);
        expect_wr(5, 32'h1234_5678);
        nxt();
        alu_valid = 0;
        chk("t1_wr_en_not_yet", 32'(wr_en), 0);
        chk("t1_hit_queued", 32'(lk_hit1), 1);
        chk("t1_empty_busy", 32'(empty), 0);
        nxt();
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_hit_inflight", 32'(lk_hit1), 1);
        chk("t1_data_inflight", lk_data1, byp(32'h1234_5678));
        nxt();
        chk("t1_wr_en_done", 32'(wr_en), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_hit_gone", 32'(lk_hit1), 0);

        // contention: load first
        ld_valid = 1; ld_addr = 7; ld_data = 32'h0000_0077;
        alu_valid = 1; alu_addr = 8; alu_data = 32'h0000_0088;
        #1;
        chk("t2_ld_ready", 32'(ld_ready), 1);
        chk("t2_alu_blocked", 32'(alu_ready), 0);
        expect_wr(7, 32'h0000_0077);
        nxt();
        ld_valid = 0;
        #1;
        chk("t2_alu_ready", 32'(alu_ready), 1);
        expect_wr(8, 32'h0000_0088);
        nxt();
        alu_valid = 0;
        nxt(); nxt(); nxt();
        chk("t2_empty", 32'(empty), 1);

        // r0 filter
        lk_addr1 = 0;
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF_FFFF;
        #1;
        chk("t3_alu_ready", 32'(alu_ready), 1);
        nxt();
        alu_valid = 0;
        chk("t3_hit_r0", 32'(lk_hit1), 0);
        chk("t3_empty", 32'(empty), 1);
        nxt();
        chk("t3_wr_en", 32'(wr_en), 0);
        chk("t3_hit_r0_late", 32'(lk_hit1), 0);
        nxt();

        // fill under hold
        hold = 1;
        for (int k = 0; k < 5; k++) begin
            alu_valid = 1; alu_addr = 5'(10 + k); alu_data = 32'h100 + 32'(k);
            #1;
            chk("t4_ready_fill", 32'(alu_ready), (k < DEPTH) ? 32'd1 : 32'd0);
            if (k < DEPTH) expect_wr(5'(10 + k), 32'h100 + 32'(k));
            nxt();
        end
        lk_addr1 = 12;
        #1;
        chk("t4_ready_full", 32'(alu_ready), 0);
        chk("t4_ld_ready_full", 32'(ld_ready), 0);
        chk("t4_wr_en_held", 32'(wr_en), 0);
        chk("t4_hit_12", 32'(lk_hit1), 1);
        hold = 0;
        nxt();
        chk("t4_drain0", 32'(wr_en), 1);
        chk("t4_ready_after_pop", 32'(alu_ready), 1);
        expect_wr(14, 32'h104);
        nxt();
        alu_valid = 0;
        chk("t4_drain1", 32'(wr_en), 1);
        for (int k = 2; k < 5; k++) begin
            nxt();
            chk("t4_drain_n", 32'(wr_en), 1);
        end
        nxt();
        chk("t4_wr_en_end", 32'(wr_en), 0);
        chk("t4_empty", 32'(empty), 1);

        // youngest-match bypass
        hold = 1;
        alu_valid = 1; alu_addr = 3; alu_data = 32'hA;
        expect_wr(3, 32'hA);
        nxt();
        alu_data = 32'hB;
        expect_wr(3, 32'hB);
        nxt();
        alu_valid = 0;
        lk_addr1 = 3; lk_addr2 = 4;
        #1;
        chk("t5_hit1", 32'(lk_hit1), 1);
        chk("t5_data1_youngest", lk_data1, byp(32'hB));
        chk("t5_hit2_miss", 32'(lk_hit2), 0);
        chk("t5_data2_miss", lk_data2, 0);
        hold = 0;
        nxt();
        chk("t5_queue_beats_inflight", lk_data1, byp(32'hB));
        chk("t5_hit1_mixed", 32'(lk_hit1), 1);
        nxt();
        chk("t5_inflight_only", lk_data1, byp(32'hB));
        nxt();
        chk("t5_hit1_gone", 32'(lk_hit1), 0);
        chk("t5_data1_gone", lk_data1, 0);

        // reset mid-drain
        hold = 1;
        alu_valid = 1; alu_addr = 20; alu_data = 32'hC0DE_0020;
        expect_wr(20, 32'hC0DE_0020);
        nxt();
        alu_addr = 21; alu_data = 32'hC0DE_0021;
        nxt();
        alu_addr = 22; alu_data = 32'hC0DE_0022;
        nxt();
        alu_valid = 0;
        hold = 0;
        nxt();
        lk_addr1 = 21; lk_addr2 = 22;
        #1;
        chk("t6_hit_before_rst", 32'(lk_hit1), 1);
        #1;
        rst = 1;
        #1;
        chk("t6_wr_en_rst", 32'(wr_en), 0);
        chk("t6_empty_rst", 32'(empty), 1);
        chk("t6_hit1_rst", 32'(lk_hit1), 0);
        chk("t6_hit2_rst", 32'(lk_hit2), 0);
        nxt(); nxt();
        rst = 0;
        for (int k = 0; k < 4; k++) nxt();
        chk("t6_no_write_after", 32'(wr_en), 0);
        chk("t6_empty_after", 32'(empty), 1);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
